// File: rtl/tl_rx_vc_cpl_buffer_ptr_ctrl.sv
// tl_rx_vc_cpl_buffer_ptr_ctrl
// Pointer and occupancy manager for one VC's completion header/data buffers.
// The write side stages data under a pending pointer and publishes it with the
// header on commit. An abort rolls the pending pointer back. The read side
// advances from the read handler's completion control bus. Each applied read
// step is echoed one cycle later as a flow-control credit return.
// Optional feature macro: CPL_PTR_ERR_CHK_EN. When defined, overflowing writes
// or commits and underflowing reads are rejected and raise sticky error flags.
// When undefined, every increment applies and the error outputs are tied low.
module tl_rx_vc_cpl_buffer_ptr_ctrl #(
  parameter int HDR_DEPTH_LOG2       = 5,
  parameter int DATA_DEPTH_LOG2      = 8,
  parameter int R_CTRL_BUS_WIDTH     = 6,
  parameter int DATA_INCR_MODE_WIDTH = 3,
  parameter int WR_INC_WIDTH         = 3
) (
  input  logic                            i_clk,
  input  logic                            i_n_rst,
  input  logic                            i_data_wr_en,
  input  logic [WR_INC_WIDTH-1:0]         i_data_wr_count,
  input  logic                            i_cpl_commit,
  input  logic                            i_cpl_abort,
  input  logic [R_CTRL_BUS_WIDTH-1:0]     i_r_completion_ctrl,
  output logic [HDR_DEPTH_LOG2-1:0]       o_hdr_wr_addr,
  output logic [HDR_DEPTH_LOG2-1:0]       o_hdr_rd_addr,
  output logic [DATA_DEPTH_LOG2-1:0]      o_data_wr_addr,
  output logic [DATA_DEPTH_LOG2-1:0]      o_data_rd_addr,
  output logic [1:0]                      o_vcn_cpl_r_empty_flags,
  output logic                            o_hdr_full,
  output logic [DATA_DEPTH_LOG2:0]        o_data_free,
  output logic                            o_fc_hdr_ret,
  output logic [DATA_INCR_MODE_WIDTH-1:0] o_fc_data_ret,
  output logic                            o_ovf_err,
  output logic                            o_unf_err
);

  // Pointer widths carry one extra wrap bit above the address.
  localparam int HP = HDR_DEPTH_LOG2 + 1;
  localparam int DP = DATA_DEPTH_LOG2 + 1;
  localparam int IW = R_CTRL_BUS_WIDTH - 3;

  logic [HP-1:0] r_hdr_wr;
  logic [HP-1:0] r_hdr_rd;
  logic [DP-1:0] r_data_pend_wr;
  logic [DP-1:0] r_data_cmt_wr;
  logic [DP-1:0] r_data_rd;
  logic                            r_fc_hdr_ret;
  logic [DATA_INCR_MODE_WIDTH-1:0] r_fc_data_ret;
  logic                            r_ovf_err;
  logic                            r_unf_err;

  // Read-side bus fields; the alignment bit (LSB) is not used here.
  logic          w_hdr_inc_en;
  logic          w_data_inc_en;
  logic [IW-1:0] w_inc_value;
  assign w_hdr_inc_en  = i_r_completion_ctrl[R_CTRL_BUS_WIDTH-1];
  assign w_data_inc_en = i_r_completion_ctrl[R_CTRL_BUS_WIDTH-2];
  assign w_inc_value   = i_r_completion_ctrl[R_CTRL_BUS_WIDTH-3:1];

  logic [DP-1:0] w_wr_cnt;
  logic [DP-1:0] w_rd_cnt;
  logic [DP-1:0] w_occ_pend;
  logic [DP-1:0] w_occ_cmt;
  logic [DP-1:0] w_data_free;
  logic          w_hdr_empty;
  logic          w_data_empty;
  logic          w_hdr_full;

  assign w_wr_cnt     = DP'(i_data_wr_count);
  assign w_rd_cnt     = DP'(w_inc_value);
  assign w_occ_pend   = r_data_pend_wr - r_data_rd;
  assign w_occ_cmt    = r_data_cmt_wr - r_data_rd;
  // Capacity minus pending occupancy; 0..2^DATA_DEPTH_LOG2 fits in DP bits.
  assign w_data_free  = DP'(2 ** DATA_DEPTH_LOG2) - w_occ_pend;
  assign w_hdr_empty  = (r_hdr_wr == r_hdr_rd);
  assign w_data_empty = (r_data_cmt_wr == r_data_rd);
  assign w_hdr_full   = ((r_hdr_wr ^ r_hdr_rd) == {1'b1, {HDR_DEPTH_LOG2{1'b0}}});

  // Acceptance of each increment. An abort discards the same-cycle write and
  // suppresses the commit, so neither is counted as an overflow attempt.
  logic w_wr_ok;
  logic w_cmt_ok;
  logic w_hdr_rd_ok;
  logic w_data_rd_ok;
  logic w_ovf_evt;
  logic w_unf_evt;

`ifdef CPL_PTR_ERR_CHK_EN
  logic w_wr_req;
  logic w_cmt_req;
  assign w_wr_req     = i_data_wr_en && !i_cpl_abort;
  assign w_cmt_req    = i_cpl_commit && !i_cpl_abort;
  assign w_wr_ok      = w_wr_req && (w_wr_cnt <= w_data_free);
  assign w_cmt_ok     = w_cmt_req && !w_hdr_full;
  assign w_hdr_rd_ok  = w_hdr_inc_en && !w_hdr_empty;
  assign w_data_rd_ok = w_data_inc_en && (w_rd_cnt <= w_occ_cmt);
  assign w_ovf_evt    = (w_wr_req && !w_wr_ok) || (w_cmt_req && !w_cmt_ok);
  assign w_unf_evt    = (w_hdr_inc_en && !w_hdr_rd_ok) || (w_data_inc_en && !w_data_rd_ok);
`else
  assign w_wr_ok      = i_data_wr_en && !i_cpl_abort;
  assign w_cmt_ok     = i_cpl_commit && !i_cpl_abort;
  assign w_hdr_rd_ok  = w_hdr_inc_en;
  assign w_data_rd_ok = w_data_inc_en;
  assign w_ovf_evt    = 1'b0;
  assign w_unf_evt    = 1'b0;
`endif

  // Pending pointer including this cycle's accepted write; this is what a
  // commit publishes.
  logic [DP-1:0] w_pend_plus;
  assign w_pend_plus = r_data_pend_wr + (w_wr_ok ? w_wr_cnt : '0);

  // Write-side and read-side pointer updates, applied independently.
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_hdr_wr       <= '0;
      r_hdr_rd       <= '0;
      r_data_pend_wr <= '0;
      r_data_cmt_wr  <= '0;
      r_data_rd      <= '0;
    end else begin
      if (i_cpl_abort) begin
        r_data_pend_wr <= r_data_cmt_wr;
      end else begin
        r_data_pend_wr <= w_pend_plus;
      end
      if (w_cmt_ok) begin
        r_data_cmt_wr <= w_pend_plus;
        r_hdr_wr      <= r_hdr_wr + 1'b1;
      end
      if (w_hdr_rd_ok) begin
        r_hdr_rd <= r_hdr_rd + 1'b1;
      end
      if (w_data_rd_ok) begin
        r_data_rd <= r_data_rd + w_rd_cnt;
      end
    end
  end

  // Credit returns echo the applied read steps; error flags are sticky.
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_fc_hdr_ret  <= 1'b0;
      r_fc_data_ret <= '0;
      r_ovf_err     <= 1'b0;
      r_unf_err     <= 1'b0;
    end else begin
      r_fc_hdr_ret  <= w_hdr_rd_ok;
      r_fc_data_ret <= w_data_rd_ok ? DATA_INCR_MODE_WIDTH'(w_inc_value) : '0;
      r_ovf_err     <= r_ovf_err | w_ovf_evt;
      r_unf_err     <= r_unf_err | w_unf_evt;
    end
  end

  assign o_hdr_wr_addr           = r_hdr_wr[HDR_DEPTH_LOG2-1:0];
  assign o_hdr_rd_addr           = r_hdr_rd[HDR_DEPTH_LOG2-1:0];
  assign o_data_wr_addr          = r_data_pend_wr[DATA_DEPTH_LOG2-1:0];
  assign o_data_rd_addr          = r_data_rd[DATA_DEPTH_LOG2-1:0];
  assign o_vcn_cpl_r_empty_flags = {w_hdr_empty, w_data_empty};
  assign o_hdr_full              = w_hdr_full;
  assign o_data_free             = w_data_free;
  assign o_fc_hdr_ret            = r_fc_hdr_ret;
  assign o_fc_data_ret           = r_fc_data_ret;
  assign o_ovf_err               = r_ovf_err;
  assign o_unf_err               = r_unf_err;

endmodule

// File: tb/tb_tl_rx_vc_cpl_buffer_ptr_ctrl.sv
// Bench for tl_rx_vc_cpl_buffer_ptr_ctrl: an occupancy-count model checked
// against the DUT every cycle, plus hand-computed literal checkpoints.
module tb_tl_rx_vc_cpl_buffer_ptr_ctrl;

  logic       i_clk;
  logic       i_n_rst;
  logic       i_data_wr_en;
  logic [2:0] i_data_wr_count;
  logic       i_cpl_commit;
  logic       i_cpl_abort;
  logic [5:0] i_r_completion_ctrl;
  logic [4:0] o_hdr_wr_addr;
  logic [4:0] o_hdr_rd_addr;
  logic [7:0] o_data_wr_addr;
  logic [7:0] o_data_rd_addr;
  logic [1:0] o_vcn_cpl_r_empty_flags;
  logic       o_hdr_full;
  logic [8:0] o_data_free;
  logic       o_fc_hdr_ret;
  logic [2:0] o_fc_data_ret;
  logic       o_ovf_err;
  logic       o_unf_err;

  int n_checks = 0;
  int n_errors = 0;

  tl_rx_vc_cpl_buffer_ptr_ctrl dut (
    .i_clk                  (i_clk),
    .i_n_rst                (i_n_rst),
    .i_data_wr_en           (i_data_wr_en),
    .i_data_wr_count        (i_data_wr_count),
    .i_cpl_commit           (i_cpl_commit),
    .i_cpl_abort            (i_cpl_abort),
    .i_r_completion_ctrl    (i_r_completion_ctrl),
    .o_hdr_wr_addr          (o_hdr_wr_addr),
    .o_hdr_rd_addr          (o_hdr_rd_addr),
    .o_data_wr_addr         (o_data_wr_addr),
    .o_data_rd_addr         (o_data_rd_addr),
    .o_vcn_cpl_r_empty_flags(o_vcn_cpl_r_empty_flags),
    .o_hdr_full             (o_hdr_full),
    .o_data_free            (o_data_free),
    .o_fc_hdr_ret           (o_fc_hdr_ret),
    .o_fc_data_ret          (o_fc_data_ret),
    .o_ovf_err              (o_ovf_err),
    .o_unf_err              (o_unf_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int md(input int v, input int m);
    return ((v % m) + m) % m;
  endfunction

  // Model: absolute positions of written/committed/read data and headers.
  int m_pend, m_cmt, m_rd, m_hw, m_hr;
  int m_fch, m_fcd, m_ovf, m_unf;

  always @(posedge i_clk or negedge i_n_rst) begin
    int occ_p, occ_c, free, hcnt, v;
    bit wr_take, cmt_take, h_take, d_take;
    if (!i_n_rst) begin
      m_pend = 0; m_cmt = 0; m_rd = 0; m_hw = 0; m_hr = 0;
      m_fch = 0; m_fcd = 0; m_ovf = 0; m_unf = 0;
    end else begin
      occ_p = md(m_pend - m_rd, 512);
      occ_c = md(m_cmt - m_rd, 512);
      free  = 256 - occ_p;
      hcnt  = md(m_hw - m_hr, 64);
      v     = int'(i_r_completion_ctrl[3:1]);
      wr_take  = i_data_wr_en && !i_cpl_abort;
      cmt_take = i_cpl_commit && !i_cpl_abort;
      h_take   = i_r_completion_ctrl[5];
      d_take   = i_r_completion_ctrl[4];
`ifdef CPL_PTR_ERR_CHK_EN
      if (wr_take && int'(i_data_wr_count) > free) begin wr_take = 0; m_ovf = 1; end
      if (cmt_take && hcnt == 32) begin cmt_take = 0; m_ovf = 1; end
      if (h_take && hcnt == 0) begin h_take = 0; m_unf = 1; end
      if (d_take && v > occ_c) begin d_take = 0; m_unf = 1; end
`endif
      if (wr_take) m_pend = md(m_pend + int'(i_data_wr_count), 512);
      if (cmt_take) begin
        m_cmt = m_pend;
        m_hw  = md(m_hw + 1, 64);
      end
      if (i_cpl_abort) m_pend = m_cmt;
      if (h_take) m_hr = md(m_hr + 1, 64);
      if (d_take) m_rd = md(m_rd + v, 512);
      m_fch = h_take ? 1 : 0;
      m_fcd = d_take ? v : 0;
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge i_clk) begin
    int hc, oc;
    hc = md(m_hw - m_hr, 64);
    oc = md(m_cmt - m_rd, 512);
    chk("m_flags", int'(o_vcn_cpl_r_empty_flags), ((hc == 0) ? 2 : 0) + ((oc == 0) ? 1 : 0));
    chk("m_full", int'(o_hdr_full), (hc == 32) ? 1 : 0);
    chk("m_free", int'(o_data_free), 256 - md(m_pend - m_rd, 512));
    chk("m_hwa", int'(o_hdr_wr_addr), m_hw % 32);
    chk("m_hra", int'(o_hdr_rd_addr), m_hr % 32);
    chk("m_dwa", int'(o_data_wr_addr), m_pend % 256);
    chk("m_dra", int'(o_data_rd_addr), m_rd % 256);
    chk("m_fch", int'(o_fc_hdr_ret), m_fch);
    chk("m_fcd", int'(o_fc_data_ret), m_fcd);
    chk("m_ovf", int'(o_ovf_err), m_ovf);
    chk("m_unf", int'(o_unf_err), m_unf);
  end

  task automatic drive(input bit we, input int cnt, input bit cm, input bit ab,
                       input bit hi, input bit di, input int iv);
    logic [2:0] c3;
    logic [2:0] v3;
    c3 = 3'(cnt);
    v3 = 3'(iv);
    @(negedge i_clk);
    i_data_wr_en        = we;
    i_data_wr_count     = c3;
    i_cpl_commit        = cm;
    i_cpl_abort         = ab;
    i_r_completion_ctrl = {hi, di, v3, 1'b0};
    $display("cyc t=%0t wr=%0d cnt=%0d cmt=%0d abt=%0d hinc=%0d dinc=%0d v=%0d",
             $time, we, cnt, cm, ab, hi, di, iv);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    i_n_rst = 1'b0;
    i_data_wr_en = 0; i_data_wr_count = 0; i_cpl_commit = 0;
    i_cpl_abort = 0; i_r_completion_ctrl = 0;
    @(negedge i_clk); #1;
    // 1. reset state
    chk("rst_flags", int'(o_vcn_cpl_r_empty_flags), 3);
    chk("rst_free", int'(o_data_free), 256);
    chk("rst_dwa", int'(o_data_wr_addr), 0);
    chk("rst_hwa", int'(o_hdr_wr_addr), 0);
    chk("rst_full", int'(o_hdr_full), 0);
    chk("rst_errs", int'({o_ovf_err, o_unf_err}), 0);
    chk("rst_fc", int'({o_fc_hdr_ret, o_fc_data_ret}), 0);
    i_n_rst = 1'b1;

    // 2. write 4,4,3 with commit on the last beat, then read it back
    drive(1, 4, 0, 0, 0, 0, 0);
    drive(1, 4, 0, 0, 0, 0, 0);
    drive(1, 3, 1, 0, 0, 0, 0);
    idle(); #1;
    chk("t2_flags", int'(o_vcn_cpl_r_empty_flags), 0);
    chk("t2_free", int'(o_data_free), 245);
    chk("t2_dwa", int'(o_data_wr_addr), 11);
    chk("t2_hwa", int'(o_hdr_wr_addr), 1);
    drive(0, 0, 0, 0, 1, 1, 4);
    drive(0, 0, 0, 0, 0, 1, 4); #1;
    chk("t2_fcd0", int'(o_fc_data_ret), 4);
    chk("t2_fch0", int'(o_fc_hdr_ret), 1);
    drive(0, 0, 0, 0, 0, 1, 3); #1;
    chk("t2_fcd1", int'(o_fc_data_ret), 4);
    chk("t2_fch1", int'(o_fc_hdr_ret), 0);
    idle(); #1;
    chk("t2_fcd2", int'(o_fc_data_ret), 3);
    chk("t2_rflags", int'(o_vcn_cpl_r_empty_flags), 3);
    chk("t2_rfree", int'(o_data_free), 256);
    chk("t2_dra", int'(o_data_rd_addr), 11);
    idle(); #1;
    chk("t2_fcd3", int'(o_fc_data_ret), 0);

    // 3. abort on third beat rolls pending back
    drive(1, 4, 0, 0, 0, 0, 0);
    drive(1, 4, 0, 0, 0, 0, 0);
    drive(1, 2, 0, 1, 0, 0, 0);
    idle(); #1;
    chk("t3_flags", int'(o_vcn_cpl_r_empty_flags), 3);
    chk("t3_free", int'(o_data_free), 256);
    chk("t3_dwa", int'(o_data_wr_addr), 11);

    // 4. advance both pointers to 252, then wrap with a 4-entry TLP
    for (int i = 0; i < 60; i++) drive(1, 4, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 4);
    for (int i = 0; i < 59; i++) drive(0, 0, 0, 0, 0, 1, 4);
    drive(0, 0, 0, 0, 0, 1, 1);
    idle(); #1;
    chk("t4_pre_dwa", int'(o_data_wr_addr), 252);
    chk("t4_pre_dra", int'(o_data_rd_addr), 252);
    chk("t4_pre_flags", int'(o_vcn_cpl_r_empty_flags), 3);
    drive(1, 4, 1, 0, 0, 0, 0);
    idle(); #1;
    chk("t4_dwa", int'(o_data_wr_addr), 0);
    chk("t4_flags", int'(o_vcn_cpl_r_empty_flags), 0);
    chk("t4_free", int'(o_data_free), 252);
    drive(0, 0, 0, 0, 1, 1, 4);
    idle(); #1;
    chk("t4_dra", int'(o_data_rd_addr), 0);
    chk("t4_rflags", int'(o_vcn_cpl_r_empty_flags), 3);

    // 6a. concurrent read 4 and write 4 + commit at occupancy 8
    drive(1, 4, 0, 0, 0, 0, 0);
    drive(1, 4, 1, 0, 0, 0, 0);
    idle(); #1;
    chk("t6_free0", int'(o_data_free), 248);
    drive(1, 4, 1, 0, 0, 1, 4);
    idle(); #1;
    chk("t6_free1", int'(o_data_free), 248);
    chk("t6_dwa", int'(o_data_wr_addr), 12);
    chk("t6_dra", int'(o_data_rd_addr), 4);
    drive(0, 0, 0, 0, 1, 1, 4);
    drive(0, 0, 0, 0, 1, 1, 4);
    idle(); #1;
    chk("t6_flags", int'(o_vcn_cpl_r_empty_flags), 3);

    // 5. fill the header buffer (5 headers consumed so far)
    for (int i = 0; i < 32; i++) drive(0, 0, 1, 0, 0, 0, 0);
    idle(); #1;
    chk("t5_full", int'(o_hdr_full), 1);
    chk("t5_hwa", int'(o_hdr_wr_addr), 5);
    chk("t5_flags", int'(o_vcn_cpl_r_empty_flags), 1);
    drive(0, 0, 1, 0, 0, 0, 0);
    idle(); #1;
`ifdef CPL_PTR_ERR_CHK_EN
    chk("t5_ovf", int'(o_ovf_err), 1);
    chk("t5_hwa33", int'(o_hdr_wr_addr), 5);
    chk("t5_full33", int'(o_hdr_full), 1);
    for (int i = 0; i < 32; i++) drive(0, 0, 0, 0, 1, 0, 0);
`else
    chk("t5_ovf", int'(o_ovf_err), 0);
    chk("t5_hwa33", int'(o_hdr_wr_addr), 6);
    chk("t5_full33", int'(o_hdr_full), 0);
    for (int i = 0; i < 33; i++) drive(0, 0, 0, 0, 1, 0, 0);
`endif
    idle(); #1;
    chk("t5_dflags", int'(o_vcn_cpl_r_empty_flags), 3);

`ifdef CPL_PTR_ERR_CHK_EN
    // 6b. read 5 at occupancy 3 is rejected
    drive(1, 3, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 5);
    idle(); #1;
    chk("t6_unf", int'(o_unf_err), 1);
    chk("t6_fcd", int'(o_fc_data_ret), 0);
    chk("t6_fch", int'(o_fc_hdr_ret), 1);
    chk("t6_free3", int'(o_data_free), 253);
`endif

    // Mid-TLP reset drops pending data
    drive(1, 4, 0, 0, 0, 0, 0);
    idle(); #2;
    i_n_rst = 1'b0; #1;
    chk("mr_free", int'(o_data_free), 256);
    chk("mr_dwa", int'(o_data_wr_addr), 0);
    chk("mr_errs", int'({o_ovf_err, o_unf_err}), 0);
    idle(); idle();
    i_n_rst = 1'b1;
    idle(); idle(); #1;
    chk("mr_flags", int'(o_vcn_cpl_r_empty_flags), 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
